// File: rtl/bip_mem_server_pkg.sv
// Shared definitions for the BIP memory server.
//   - run-control FSM state encoding (3 bits)
//   - byte width of the UART-side streams
//   - memory depth helper derived from the address width
package bip_mem_server_pkg;

  localparam int BYTE_W        = 8;
  localparam int NBITS_O_DEF   = 11;
  localparam int MEM_DEPTH_DEF = 1 << NBITS_O_DEF;

  typedef enum logic [2:0] {
    ST_LEN_LO  = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LOAD_LO = 3'd2,
    ST_LOAD_HI = 3'd3,
    ST_RUN     = 3'd4,
    ST_DUMP_LO = 3'd5,
    ST_DUMP_HI = 3'd6
  } state_t;

  // Number of words in a memory addressed by nbits address bits.
  function automatic int mem_depth(input int nbits);
    return 1 << nbits;
  endfunction

endpackage

// File: rtl/bip_ram.sv
// Word array with one synchronous write port and one asynchronous read port.
// Contents are deliberately not reset so a loaded program survives a reset.
// Ports:
//   i_clk    write clock
//   i_we     write enable (write on rising edge)
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  read data, combinational from i_raddr
module bip_ram
  import bip_mem_server_pkg::*;
#(
  parameter int AW = 11,
  parameter int DW = 16
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  localparam int DEPTH = mem_depth(AW);

  logic [DW-1:0] mem [0:DEPTH-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  // Read-before-write: a same-cycle read sees the old word.
  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/bip_mem_server.sv
// Memory-side responder and run control for the BIP CPU.
// After reset the CPU is held while program memory is loaded from a byte
// stream (16-bit little-endian word count, then little-endian words). The CPU
// then runs; on halt the first DUMP_WORDS data words are streamed out
// little-endian, and the block returns to waiting for a new program.
// Ports:
//   i_clk, i_reset          clock, asynchronous active-low reset
//   i_PmAddr/o_Instruction  program fetch port (0 while CPU held)
//   i_DmAddr/i_Rd/i_Wr      data port; i_InData write data, o_OutData read data
//   i_Halt/o_CpuRun         CPU halt flag in, CPU release out
//   i_RxData/i_RxValid/o_RxReady  byte stream in
//   o_TxData/o_TxValid/i_TxReady  byte stream out
//   o_State                 current FSM state (debug)
//
// Handshakes (both byte streams): a byte moves on a rising edge where valid
// and ready are both 1. The sender holds data stable while valid=1 and
// ready=0; valid does not depend on ready. Back-to-back transfers are allowed.
module bip_mem_server
  import bip_mem_server_pkg::*;
#(
  parameter int NBITS_O    = 11,
  parameter int NBITS_D    = 16,
  parameter int DUMP_WORDS = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NBITS_O-1:0] i_PmAddr,
  output logic [NBITS_D-1:0] o_Instruction,
  input  logic [NBITS_O-1:0] i_DmAddr,
  input  logic               i_Rd,
  input  logic               i_Wr,
  input  logic [NBITS_D-1:0] i_InData,
  output logic [NBITS_D-1:0] o_OutData,
  input  logic               i_Halt,
  output logic               o_CpuRun,
  input  logic [BYTE_W-1:0]  i_RxData,
  input  logic               i_RxValid,
  output logic               o_RxReady,
  output logic [BYTE_W-1:0]  o_TxData,
  output logic               o_TxValid,
  input  logic               i_TxReady,
  output state_t             o_State
);

  localparam logic [NBITS_O-1:0] ADDR_ONE  = NBITS_O'(1);
  localparam logic [NBITS_O-1:0] LAST_DUMP = NBITS_O'(DUMP_WORDS - 1);

  state_t             state;
  logic               cpu_run;
  logic               tx_valid;
  logic [BYTE_W-1:0]  len_lo;
  logic [BYTE_W-1:0]  load_lo;
  logic [15:0]        words_left;
  logic [NBITS_O-1:0] load_addr;
  logic [NBITS_O-1:0] dump_addr;

  logic               rx_fire;
  logic               tx_fire;
  logic               dump_active;
  logic               pm_we;
  logic               dm_we;
  logic [NBITS_D-1:0] pm_wdata;
  logic [NBITS_D-1:0] pm_q;
  logic [NBITS_D-1:0] dm_q;
  logic [NBITS_O-1:0] dm_raddr;
  logic [15:0]        rx_count;

  assign o_RxReady   = (state == ST_LEN_LO)  || (state == ST_LEN_HI) ||
                       (state == ST_LOAD_LO) || (state == ST_LOAD_HI);
  assign dump_active = (state == ST_DUMP_LO) || (state == ST_DUMP_HI);
  assign rx_fire     = i_RxValid & o_RxReady;
  assign tx_fire     = tx_valid & i_TxReady;
  assign rx_count    = {i_RxData, len_lo};

  // Program memory is written only by the loader, on the high-byte accept.
  assign pm_we    = (state == ST_LOAD_HI) && rx_fire;
  assign pm_wdata = {i_RxData, load_lo};

  // CPU writes count only while the CPU is released; this includes the halt
  // edge itself because cpu_run falls one cycle after halt is sampled.
  assign dm_we = i_Wr & cpu_run;

  // The data-memory read port is shared: the dump owns it while the CPU is
  // halted, the CPU owns it otherwise.
  assign dm_raddr = dump_active ? dump_addr : i_DmAddr;

  bip_ram #(.AW(NBITS_O), .DW(NBITS_D)) u_pm (
    .i_clk   (i_clk),
    .i_we    (pm_we),
    .i_waddr (load_addr),
    .i_wdata (pm_wdata),
    .i_raddr (i_PmAddr),
    .o_rdata (pm_q)
  );

  bip_ram #(.AW(NBITS_O), .DW(NBITS_D)) u_dm (
    .i_clk   (i_clk),
    .i_we    (dm_we),
    .i_waddr (i_DmAddr),
    .i_wdata (i_InData),
    .i_raddr (dm_raddr),
    .o_rdata (dm_q)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= ST_LEN_LO;
      cpu_run    <= 1'b0;
      tx_valid   <= 1'b0;
      len_lo     <= '0;
      load_lo    <= '0;
      words_left <= '0;
      load_addr  <= '0;
      dump_addr  <= '0;
    end else begin
      case (state)
        ST_LEN_LO: begin
          if (rx_fire) begin
            len_lo <= i_RxData;
            state  <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (rx_fire) begin
            if (rx_count == 16'd0) begin
              state   <= ST_RUN;
              cpu_run <= 1'b1;
            end else begin
              words_left <= rx_count;
              load_addr  <= '0;
              state      <= ST_LOAD_LO;
            end
          end
        end
        ST_LOAD_LO: begin
          if (rx_fire) begin
            load_lo <= i_RxData;
            state   <= ST_LOAD_HI;
          end
        end
        ST_LOAD_HI: begin
          if (rx_fire) begin
            // Address wraps naturally at the memory depth.
            load_addr  <= load_addr + ADDR_ONE;
            words_left <= words_left - 16'd1;
            if (words_left == 16'd1) begin
              state   <= ST_RUN;
              cpu_run <= 1'b1;
            end else begin
              state <= ST_LOAD_LO;
            end
          end
        end
        ST_RUN: begin
          if (i_Halt) begin
            state     <= ST_DUMP_LO;
            cpu_run   <= 1'b0;
            tx_valid  <= 1'b1;
            dump_addr <= '0;
          end
        end
        ST_DUMP_LO: begin
          if (tx_fire) begin
            state <= ST_DUMP_HI;
          end
        end
        ST_DUMP_HI: begin
          if (tx_fire) begin
            if (dump_addr == LAST_DUMP) begin
              state    <= ST_LEN_LO;
              tx_valid <= 1'b0;
            end else begin
              dump_addr <= dump_addr + ADDR_ONE;
              state     <= ST_DUMP_LO;
            end
          end
        end
        default: begin
          state    <= ST_LEN_LO;
          cpu_run  <= 1'b0;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

  // Dump bytes come straight from the addressed word; the CPU is halted so
  // data memory cannot change, which keeps o_TxData stable while stalled.
  always_comb begin
    o_TxData = '0;
    case (state)
      ST_DUMP_LO: o_TxData = dm_q[BYTE_W-1:0];
      ST_DUMP_HI: o_TxData = dm_q[2*BYTE_W-1:BYTE_W];
      default:    o_TxData = '0;
    endcase
  end

  assign o_CpuRun      = cpu_run;
  assign o_TxValid     = tx_valid;
  assign o_Instruction = cpu_run ? pm_q : '0;
  assign o_OutData     = (i_Rd && !dump_active) ? dm_q : '0;
  assign o_State       = state;

endmodule

// File: tb/tb_bip_mem_server.sv
module tb_bip_mem_server;
  import bip_mem_server_pkg::*;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DUMPW = 2;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic [AW-1:0] i_PmAddr = '0;
  logic [DW-1:0] o_Instruction;
  logic [AW-1:0] i_DmAddr = '0;
  logic          i_Rd = 1'b0;
  logic          i_Wr = 1'b0;
  logic [DW-1:0] i_InData = '0;
  logic [DW-1:0] o_OutData;
  logic          i_Halt = 1'b0;
  logic          o_CpuRun;
  logic [7:0]    i_RxData = '0;
  logic          i_RxValid = 1'b0;
  logic          o_RxReady;
  logic [7:0]    o_TxData;
  logic          o_TxValid;
  logic          i_TxReady = 1'b0;
  state_t        o_State;

  always #5 i_clk = ~i_clk;

  bip_mem_server #(.NBITS_O(AW), .NBITS_D(DW), .DUMP_WORDS(DUMPW)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_PmAddr(i_PmAddr), .o_Instruction(o_Instruction),
    .i_DmAddr(i_DmAddr), .i_Rd(i_Rd), .i_Wr(i_Wr), .i_InData(i_InData),
    .o_OutData(o_OutData), .i_Halt(i_Halt), .o_CpuRun(o_CpuRun),
    .i_RxData(i_RxData), .i_RxValid(i_RxValid), .o_RxReady(o_RxReady),
    .o_TxData(o_TxData), .o_TxValid(o_TxValid), .i_TxReady(i_TxReady),
    .o_State(o_State)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] pm_ref [DEPTH];
  bit            pm_known [DEPTH];
  logic [DW-1:0] dm_ref [DEPTH];
  bit            dm_known [DEPTH];
  bit            exp_run = 1'b0;
  logic [DW-1:0] load_buf [64];
  logic [7:0]    exp_q [$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge i_clk);
    i_RxValid = 1'b0; i_TxReady = 1'b0; i_Halt = 1'b0; i_Wr = 1'b0; i_Rd = 1'b0;
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;
    exp_run = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    repeat ($urandom_range(0, 2)) @(negedge i_clk);
    @(negedge i_clk);
    i_RxData  = b;
    i_RxValid = 1'b1;
    n = 0;
    while (!o_RxReady && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (n == 50) begin
      check("rx_ready_timeout", 32'(o_RxReady), 32'd1);
      i_RxValid = 1'b0;
    end else begin
      @(posedge i_clk);
      #1 i_RxValid = 1'b0;
    end
  endtask

  // Sends count n followed by load_buf[0..n-1]; ends #1 after the last accept.
  task automatic load_words(input int n);
    logic [15:0] cnt;
    cnt = 16'(n);
    send_byte(cnt[7:0]);
    if (n == 0) begin
      check("run_before_last", 32'(o_CpuRun), 32'd0);
      send_byte(cnt[15:8]);
    end else begin
      send_byte(cnt[15:8]);
      for (int i = 0; i < n; i++) begin
        send_byte(load_buf[i][7:0]);
        if (i == n - 1) check("run_before_last", 32'(o_CpuRun), 32'd0);
        send_byte(load_buf[i][15:8]);
        pm_ref[i % DEPTH]   = load_buf[i];
        pm_known[i % DEPTH] = 1'b1;
      end
    end
    exp_run = 1'b1;
    check("run_after_load", 32'(o_CpuRun), 32'd1);
    check("state_run", 32'(o_State), 32'(ST_RUN));
    check("rx_ready_run", 32'(o_RxReady), 32'd0);
  endtask

  task automatic pm_check_all();
    @(negedge i_clk);
    for (int a = 0; a < DEPTH; a++) begin
      if (pm_known[a]) begin
        i_PmAddr = AW'(a);
        #1 check($sformatf("pm[%0d]", a), 32'(o_Instruction), 32'(pm_ref[a]));
      end
    end
  endtask

  task automatic dm_write(input int a, input logic [DW-1:0] d);
    @(negedge i_clk);
    i_DmAddr = AW'(a); i_InData = d; i_Wr = 1'b1;
    @(posedge i_clk);
    #1 i_Wr = 1'b0;
    if (exp_run) begin
      dm_ref[a] = d;
      dm_known[a] = 1'b1;
    end
  endtask

  task automatic dm_read_check(input int a);
    @(negedge i_clk);
    i_DmAddr = AW'(a); i_Rd = 1'b1;
    #1 check($sformatf("dm_rd[%0d]", a), 32'(o_OutData), 32'(dm_ref[a]));
    i_Rd = 1'b0;
    #1 check("dm_rd_low", 32'(o_OutData), 32'd0);
  endtask

  // Halt (optionally writing on the halt edge), then collect the dump.
  task automatic halt_and_dump(input bit wr, input int wa, input logic [DW-1:0] wd, input bit stall);
    int idx;
    int stall_cnt;
    int cyc;
    @(negedge i_clk);
    i_Halt = 1'b1;
    if (wr) begin
      i_DmAddr = AW'(wa); i_InData = wd; i_Wr = 1'b1;
    end
    @(posedge i_clk);
    #1 i_Halt = 1'b0;
    i_Wr = 1'b0;
    if (wr) begin
      dm_ref[wa] = wd;
      dm_known[wa] = 1'b1;
    end
    exp_run = 1'b0;
    check("run_after_halt", 32'(o_CpuRun), 32'd0);
    check("state_dump", 32'(o_State), 32'(ST_DUMP_LO));
    check("rx_ready_dump", 32'(o_RxReady), 32'd0);
    for (int w = 0; w < DUMPW; w++) begin
      exp_q.push_back(dm_ref[w][7:0]);
      exp_q.push_back(dm_ref[w][15:8]);
    end
    idx = 0; stall_cnt = 0; cyc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      @(negedge i_clk);
      cyc++;
      if (!o_TxValid) begin
        check("tx_valid_dump", 32'(o_TxValid), 32'd1);
        break;
      end
      if (stall && idx == 1 && stall_cnt < 3) begin
        i_TxReady = 1'b0;
        stall_cnt++;
        check("tx_stable", 32'(o_TxData), 32'(exp_q[0]));
      end else begin
        i_TxReady = 1'($urandom_range(0, 1));
        if (i_TxReady) begin
          check($sformatf("tx_byte%0d", idx), 32'(o_TxData), 32'(exp_q.pop_front()));
          idx++;
        end
      end
    end
    if (exp_q.size() > 0) begin
      check("dump_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(negedge i_clk);
    i_TxReady = 1'b0;
    #1;
    check("tx_valid_done", 32'(o_TxValid), 32'd0);
    check("tx_data_done", 32'(o_TxData), 32'd0);
    check("state_len_lo", 32'(o_State), 32'(ST_LEN_LO));
    check("rx_ready_done", 32'(o_RxReady), 32'd1);
    check("run_done", 32'(o_CpuRun), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int a = 0; a < DEPTH; a++) begin
      pm_known[a] = 1'b0; dm_known[a] = 1'b0;
      pm_ref[a] = '0; dm_ref[a] = '0;
    end

    // Reset state.
    do_reset();
    #1;
    check("rst_run", 32'(o_CpuRun), 32'd0);
    check("rst_rx_ready", 32'(o_RxReady), 32'd1);
    check("rst_tx_valid", 32'(o_TxValid), 32'd0);
    check("rst_tx_data", 32'(o_TxData), 32'd0);
    check("rst_state", 32'(o_State), 32'(ST_LEN_LO));
    for (int k = 0; k < 4; k++) begin
      i_PmAddr = AW'($urandom_range(0, DEPTH - 1));
      #1 check("rst_nop", 32'(o_Instruction), 32'd0);
    end

    // Two-word load with gaps.
    load_buf[0] = 16'h1234;
    load_buf[1] = 16'hABCD;
    load_words(2);
    pm_check_all();

    // Data port accesses.
    dm_write(5, 16'h00FF);
    dm_read_check(5);
    @(negedge i_clk);
    i_DmAddr = AW'(5); i_Rd = 1'b1; i_Wr = 1'b1; i_InData = 16'h1111;
    #1 check("rdwr_old", 32'(o_OutData), 32'h00FF);
    @(posedge i_clk);
    #1 i_Wr = 1'b0;
    dm_ref[5] = 16'h1111;
    check("rdwr_new", 32'(o_OutData), 32'h1111);
    i_Rd = 1'b0;
    dm_write(2, 16'h5A5A);
    for (int k = 0; k < 16; k++) begin
      int a;
      a = $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 1) == 1 || !dm_known[a]) dm_write(a, DW'($urandom));
      else dm_read_check(a);
    end
    dm_write(0, 16'h1234);

    // Halt with a write on the halt edge, stall on the second byte.
    halt_and_dump(1'b1, 1, 16'hBEEF, 1'b1);

    // Halt outside RUN is ignored; writes while held are ignored.
    @(negedge i_clk);
    i_Halt = 1'b1;
    repeat (3) @(negedge i_clk);
    check("halt_ignored", 32'(o_State), 32'(ST_LEN_LO));
    i_Halt = 1'b0;
    dm_write(2, 16'hDEAD);

    // Zero-count load: straight to RUN, PM unchanged.
    load_words(0);
    pm_check_all();
    dm_read_check(2);
    halt_and_dump(1'b0, 0, '0, 1'b0);

    // Load longer than the memory depth wraps and overwrites from 0.
    for (int i = 0; i < DEPTH + 2; i++) load_buf[i] = DW'($urandom);
    load_words(DEPTH + 2);
    pm_check_all();

    // Reset mid-dump drops TX valid immediately.
    @(negedge i_clk);
    i_Halt = 1'b1; i_TxReady = 1'b0;
    @(posedge i_clk);
    #1 i_Halt = 1'b0;
    exp_run = 1'b0;
    check("middump_valid", 32'(o_TxValid), 32'd1);
    i_reset = 1'b0;
    #1;
    check("middump_rst_valid", 32'(o_TxValid), 32'd0);
    check("middump_rst_state", 32'(o_State), 32'(ST_LEN_LO));
    @(negedge i_clk);
    i_reset = 1'b1;

    // Reset mid-load after the first word of a three-word load.
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h77);
    send_byte(8'h66);
    pm_ref[0] = 16'h6677;
    do_reset();
    #1;
    check("midload_state", 32'(o_State), 32'(ST_LEN_LO));
    check("midload_run", 32'(o_CpuRun), 32'd0);
    check("midload_rx_ready", 32'(o_RxReady), 32'd1);
    load_words(0);
    pm_check_all();
    halt_and_dump(1'b0, 0, '0, 1'b0);

    // A fresh load after all of that.
    load_buf[0] = DW'($urandom);
    load_buf[1] = DW'($urandom);
    load_buf[2] = DW'($urandom);
    load_words(3);
    pm_check_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
